// File: rtl/pixel_intensity_mapper_if.sv
// rtl/pixel_intensity_mapper_if.sv - valid/ready pixel stream bundle for pixel_intensity_mapper
interface pixel_intensity_mapper_if #(
  parameter int PIX_W = 8
) ();
  logic             valid;
  logic             ready;
  logic [PIX_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pixel_intensity_mapper.sv
// rtl/pixel_intensity_mapper.sv - streaming grey-scale point mapper with saturation and frame counting
// Optional PIXMAP_SATCNT_EN adds the per-frame clipped-pixel counter sat_count.
module pixel_intensity_mapper #(
  parameter int PIX_W  = 8,
  parameter int CNT_W  = 24,
  parameter int FRAC_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_gain,
  input  logic [PIX_W-1:0]      cfg_offset,
  input  logic [CNT_W-1:0]      cfg_pixels,
  pixel_intensity_mapper_if.slave  s_pix,
  pixel_intensity_mapper_if.master m_pix,
  output logic                  busy,
  output logic                  frame_done
`ifdef PIXMAP_SATCNT_EN
  ,
  output logic [CNT_W-1:0]      sat_count
`endif
);

  localparam int L_W = $clog2(PIX_W + 1);
  localparam int X_W = (2 * L_W > PIX_W) ? 2 * L_W : PIX_W;
  localparam int P_W = X_W + 8;
  localparam int Y_W = P_W + 1;
  localparam logic [PIX_W-1:0] PMAX = '1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [1:0]       mode_r;
  logic [7:0]       gain_r;
  logic [PIX_W-1:0] offset_r;
  logic [CNT_W-1:0] pixels_r;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  logic             v1;
  logic [X_W-1:0]   x1;
  logic [PIX_W-1:0] raw1;

  logic             en;
  logic             s_hs;
  logic             m_hs;
  logic [CNT_W-1:0] out_next;

  // Ceiling log2, with 0 and 1 both mapping to 0.
  function automatic logic [L_W-1:0] ceil_log2(input logic [PIX_W-1:0] v);
    logic [L_W-1:0] l;
    l = '0;
    for (int i = 0; i < PIX_W; i++) begin
      if ({1'b0, v} > ({{PIX_W{1'b0}}, 1'b1} << i))
        l = L_W'(i + 1);
    end
    return l;
  endfunction

  assign en          = !m_pix.valid || m_pix.ready;
  assign s_pix.ready = busy && en && (in_cnt < pixels_r);
  assign s_hs        = s_pix.valid && s_pix.ready;
  assign m_hs        = m_pix.valid && m_pix.ready;
  assign out_next    = out_cnt + CNT_W'(1);

  logic [X_W-1:0] lx;
  logic [X_W-1:0] x_in;
  always_comb begin
    lx   = X_W'(ceil_log2(s_pix.data));
    x_in = (mode_r == 2'b01) ? lx * lx : X_W'(s_pix.data);
  end

  // Stage 2 keeps full precision up to the final clip.
  logic [P_W-1:0]   prod;
  logic [Y_W-1:0]   y;
  logic             sat;
  logic [PIX_W-1:0] y_clip;
  always_comb begin
    prod = P_W'(x1) * P_W'(gain_r);
    case (mode_r)
      2'b10:   y = Y_W'(PMAX - raw1);
      2'b11:   y = Y_W'(raw1);
      default: y = {1'b0, prod >> FRAC_W} + Y_W'(offset_r);
    endcase
    sat    = y > Y_W'(PMAX);
    y_clip = sat ? PMAX : y[PIX_W-1:0];
  end

`ifdef PIXMAP_SATCNT_EN
  logic m_sat;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      mode_r      <= '0;
      gain_r      <= '0;
      offset_r    <= '0;
      pixels_r    <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      v1          <= 1'b0;
      x1          <= '0;
      raw1        <= '0;
      m_pix.valid <= 1'b0;
      m_pix.data  <= '0;
`ifdef PIXMAP_SATCNT_EN
      m_sat       <= 1'b0;
      sat_count   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        v1          <= s_hs;
        x1          <= x_in;
        raw1        <= s_pix.data;
        m_pix.valid <= v1;
        m_pix.data  <= y_clip;
`ifdef PIXMAP_SATCNT_EN
        m_sat       <= sat;
`endif
      end
      if (s_hs)
        in_cnt <= in_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            mode_r   <= cfg_mode;
            gain_r   <= cfg_gain;
            offset_r <= cfg_offset;
            pixels_r <= cfg_pixels;
            in_cnt   <= '0;
            out_cnt  <= '0;
`ifdef PIXMAP_SATCNT_EN
            sat_count <= '0;
`endif
            if (cfg_pixels == '0) begin
              frame_done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (m_hs) begin
            out_cnt <= out_next;
`ifdef PIXMAP_SATCNT_EN
            if (m_sat)
              sat_count <= sat_count + CNT_W'(1);
`endif
            if (out_next == pixels_r) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
